// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   Pipelined WIDTH-bit adder. The add is split into CHUNK-bit slices, and each
//   pipeline stage adds one slice. The carry between slices is registered.
//   Valid/ready handshakes on the input and output sides. The block accepts one
//   operation per cycle, and its latency is STAGES = WIDTH/CHUNK cycles.
//
//   Optional feature macro: OVF_FLAG_EN. When it is defined, the ovf port
//   (signed overflow, aligned with sum) is present.
//
// Ports
//   Clk       in   1      clock; all state changes on the rising edge
//   Rst       in   1      synchronous, active-high reset
//   inValid   in   1      a/b/cIn valid this cycle
//   inReady   out  1      block can accept (transfer on inValid && inReady)
//   a, b      in   WIDTH  operands
//   cIn       in   1      carry into bit 0
//   outValid  out  1      sum/cOut (and ovf) valid
//   outReady  in   1      consumer accepts (transfer on outValid && outReady)
//   sum       out  WIDTH  (a + b + cIn) mod 2^WIDTH
//   cOut      out  1      carry out of bit WIDTH-1
//   ovf       out  1      signed overflow (only with OVF_FLAG_EN)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             cOut
`ifdef OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = WIDTH / CHUNK;

    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
            $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // Stage k registers hold an operation that is waiting to add slice k.
    // The operand copies are full width. The low slices of a_r/b_r and the
    // high slices of sum_r are not meaningful at stage k, and synthesis trims
    // them away.
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] carry_r;
    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  b_r   [STAGES];
    logic [WIDTH-1:0]  sum_r [STAGES];

    logic [CHUNK:0]    slice_s  [STAGES];   // {carry, slice sum} of stage k
    logic [WIDTH-1:0]  merged_s [STAGES];   // partial sum including slice k
    logic              advance_s;

    // The whole pipeline moves together. It can move whenever the output
    // register is empty or is being drained this cycle.
    assign advance_s = !outValid || outReady;
    assign inReady   = advance_s;

    // Per-stage slice add: operand slice k plus the carry registered by stage k-1
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slice_s[k] = {1'b0, a_r[k][k*CHUNK +: CHUNK]}
                       + {1'b0, b_r[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, carry_r[k]};
            merged_s[k] = sum_r[k];
            merged_s[k][k*CHUNK +: CHUNK] = slice_s[k][CHUNK-1:0];
        end
    end

    // Stage valid bits: shift on advance, flushed by reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_r <= {STAGES{1'b0}};
        end else if (advance_s) begin
            valid_r[0] <= inValid;
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Stage data: operands are delay-aligned, and the partial sum and carry
    // move forward. Bubble slots carry don't-care data, so no reset is needed.
    always_ff @(posedge Clk) begin
        if (advance_s) begin
            a_r[0]     <= a;
            b_r[0]     <= b;
            carry_r[0] <= cIn;
            sum_r[0]   <= {WIDTH{1'b0}};
            for (int k = 1; k < STAGES; k++) begin
                a_r[k]     <= a_r[k-1];
                b_r[k]     <= b_r[k-1];
                sum_r[k]   <= merged_s[k-1];
                carry_r[k] <= slice_s[k-1][CHUNK];
            end
        end
    end

    // Output register: result fields load only when a valid slot arrives
    always_ff @(posedge Clk) begin
        if (Rst) begin
            outValid <= 1'b0;
            sum      <= {WIDTH{1'b0}};
            cOut     <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf      <= 1'b0;
`endif
        end else if (advance_s) begin
            outValid <= valid_r[STAGES-1];
            if (valid_r[STAGES-1]) begin
                sum  <= merged_s[STAGES-1];
                cOut <= slice_s[STAGES-1][CHUNK];
`ifdef OVF_FLAG_EN
                // The operand sign bits are already delay-aligned in the
                // last stage, so no extra sign-tracking flops are needed.
                ovf  <= (a_r[STAGES-1][WIDTH-1] == b_r[STAGES-1][WIDTH-1]) &&
                        (merged_s[STAGES-1][WIDTH-1] != a_r[STAGES-1][WIDTH-1]);
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
`timescale 1ns/1ps

module tb_pipe_adder;

    localparam int W = 16;
    localparam int C = 4;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cIn;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] sum;
    logic         cOut;
`ifdef OVF_FLAG_EN
    logic         ovf;
`endif

    pipe_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .inValid  (inValid),
        .inReady  (inReady),
        .a        (a),
        .b        (b),
        .cIn      (cIn),
        .outValid (outValid),
        .outReady (outReady),
        .sum      (sum),
        .cOut     (cOut)
`ifdef OVF_FLAG_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   done_rand = 1'b0;

    // Reference: plain integer addition at W+1 bits
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
        logic [W:0] full;
        exp_t       e;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Scoreboard producer: record every accepted operation; reset drops in-flight ops
    always @(negedge Clk) begin
        if (Rst) begin
            exp_q.delete();
        end else if (inValid && inReady) begin
            exp_q.push_back(model(a, b, cIn));
        end
    end

    // Monitor: compare delivered results, and check that output is held during a stall
    initial begin
        bit   stall_prev;
        exp_t held;
        exp_t e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_held", {31'd0, outValid}, 32'd1);
                    check("stall_result_held", {15'd0, cOut, sum}, {15'd0, held.c, held.s});
`ifdef OVF_FLAG_EN
                    check("stall_ovf_held", {31'd0, ovf}, {31'd0, held.o});
`endif
                end
                if (outValid && outReady) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: got sum=%0h cOut=%0b, expected no output",
                                 sum, cOut);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {15'd0, cOut, sum}, {15'd0, e.c, e.s});
`ifdef OVF_FLAG_EN
                        check("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
                    end
                end
                stall_prev = outValid && !outReady;
                held.s = sum;
                held.c = cOut;
`ifdef OVF_FLAG_EN
                held.o = ovf;
`else
                held.o = 1'b0;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one operation and hold it until it is accepted (bounded)
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        inValid = 1'b1;
        a       = x;
        b       = y;
        cIn     = ci;
        for (int t = 0; t < 200; t++) begin
            @(negedge Clk);
            if (inReady) begin
                tick();
                inValid = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got inReady=0 for 200 cycles, expected acceptance");
        tick();
        inValid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int t = 0; t < 50; t++) begin
            @(negedge Clk);
            if (outValid) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL wait_valid_timeout: got outValid=0 for 50 cycles, expected 1");
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge Clk);
            if (exp_q.size() == 0) begin
                tick();
                return;
            end
        end
        check("drain_queue_empty", exp_q.size(), 32'd0);
        tick();
    endtask

    initial begin
        Rst      = 1'b1;
        inValid  = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        cIn      = 1'b0;
        outReady = 1'b1;

        // 1: reset for 2 cycles, then check the idle state
        tick();
        tick();
        Rst = 1'b0;
        @(negedge Clk);
        check("reset_outValid", {31'd0, outValid}, 32'd0);
        check("reset_sum", {16'd0, sum}, 32'd0);
        check("reset_cOut", {31'd0, cOut}, 32'd0);
        check("reset_inReady", {31'd0, inReady}, 32'd1);
`ifdef OVF_FLAG_EN
        check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        tick();

        // 2: full carry ripple; latency is exactly 4 cycles
        send(16'hFFFF, 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check("latency_not_yet_valid", {31'd0, outValid}, 32'd0);
        end
        @(negedge Clk);
        check("latency_valid", {31'd0, outValid}, 32'd1);
        check("ripple_sum", {15'd0, cOut, sum}, {15'd0, 1'b1, 16'h0000});
        tick();

        // 3: back-to-back operations give three consecutive results
        send(16'h1234, 16'h1111, 1'b0);
        send(16'h00FF, 16'h0001, 1'b1);
        send(16'h8000, 16'h8000, 1'b0);
        wait_valid();
        @(negedge Clk);
        check("b2b_valid_2", {31'd0, outValid}, 32'd1);
        @(negedge Clk);
        check("b2b_valid_3", {31'd0, outValid}, 32'd1);
        tick();
        drain();

        // 4: fill the pipe with the consumer stalled, then release it
        outReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(16'(16'h1000 * i + 16'h0F0F), 16'(16'h0101 * (i + 1)), i[0]);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("stall_inReady_low", {31'd0, inReady}, 32'd0);
        end
        tick();
        outReady = 1'b1;
        drain();

        // 5: reset two cycles after accepting two operations flushes both
        send(16'h0102, 16'h0304, 1'b0);
        send(16'hA0A0, 16'h0B0B, 1'b1);
        tick();
        tick();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("flush_no_output", {31'd0, outValid}, 32'd0);
        end
        tick();

`ifdef OVF_FLAG_EN
        // 6: signed overflow cases
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'hFFFF, 1'b0);
        send(16'h0001, 16'h0001, 1'b0);
        drain();
`endif

        // Random traffic with bubbles and consumer back-pressure
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                end
                done_rand = 1'b1;
            end
            begin
                while (!done_rand) begin
                    outReady = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        outReady = 1'b1;
        drain();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
